// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: receiver state
// encoding, parity mode encodings and the oversampling divider calculation.
package uart_pkg;

    // Receiver FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    // Parity modes, matching the PARITY parameter values.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversampling tick, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: a one-clock pulse every DIV clocks. Shared by
// the parametrised receiver and transmitter.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider; the pulse is emitted as the count wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            os_tick <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity, stop bits and
// oversampling, 3-sample majority vote per bit, parity/framing/overrun/break
// reporting and a 1-entry valid/ready holding register towards the host.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_S0  = TW'(M - 1);
    localparam logic [TW-1:0] T_S1  = TW'(M);
    localparam logic [TW-1:0] T_DEC = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    // Reject configurations the bit timing cannot support.
    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_cfg: clock divider %0d is below 2", DIV);
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || (OVERSAMPLE != 8 && OVERSAMPLE != 16)) begin : g_par_chk
        $error("uart_rx_cfg: parameter out of range");
    end

    logic                 os_tick;
    logic                 rx_meta, rx_s;
    rx_state_t            state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bidx;
    logic                 sbit;
    logic                 idle_seen;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 stop0_zero;

    logic maj, decide, bit_end, last_stop, frame_done;
    logic exp_par, first_stop_zero;
    logic done_pe, done_fe, done_brk;

    uart_os_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .os_tick(os_tick)
    );

    // Two-flop synchroniser for the asynchronous line; presets to idle (1).
    // NOTE: non-blocking assignments make rx_s take the old rx_meta, giving a
    // true two-stage pipeline; blocking here would collapse it to one flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Bit decision and frame-completion terms, evaluated on the decision tick.
    // NOTE: every signal is assigned on every path so no latch is inferred.
    always_comb begin
        maj             = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        decide          = (tcnt == T_DEC);
        bit_end         = (tcnt == T_END);
        last_stop       = (STOP_BITS == 1) || sbit;
        frame_done      = os_tick && (state == ST_STOP) && decide && last_stop;
        exp_par         = (PARITY == PAR_ODD) ? ~(^shreg) : (^shreg);
        done_pe         = (PARITY != PAR_NONE) && (par_bit != exp_par);
        done_fe         = ferr_acc | ~maj;
        first_stop_zero = sbit ? stop0_zero : ~maj;
        done_brk        = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && first_stop_zero;
    end

    // Receive FSM; advances only on oversampling ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            bidx       <= '0;
            sbit       <= 1'b0;
            idle_seen  <= 1'b0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            stop0_zero <= 1'b0;
        end else if (os_tick) begin
            if (state != ST_IDLE) begin
                tcnt <= bit_end ? '0 : tcnt + 1'b1;
                if (tcnt == T_S0) s0 <= rx_s;
                if (tcnt == T_S1) s1 <= rx_s;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_s) idle_seen <= 1'b1;
                    if (rx_en && idle_seen && !rx_s) begin
                        // The detecting tick is tick 0 of the start bit.
                        state      <= ST_START;
                        tcnt       <= TW'(1);
                        sbit       <= 1'b0;
                        ferr_acc   <= 1'b0;
                        stop0_zero <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide && maj) begin
                        state <= ST_IDLE;
                        tcnt  <= '0;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                        bidx  <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide) shreg[bidx] <= maj;
                    if (bit_end) begin
                        if (bidx == B_LAST) state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        else                bidx  <= bidx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (decide)  par_bit <= maj;
                    if (bit_end) state   <= ST_STOP;
                end
                ST_STOP: begin
                    if (decide) begin
                        if (last_stop) begin
                            // Complete without waiting for bit end to resync early.
                            state     <= ST_IDLE;
                            tcnt      <= '0;
                            idle_seen <= 1'b0;
                        end else begin
                            ferr_acc   <= ferr_acc | ~maj;
                            stop0_zero <= ~maj;
                        end
                    end else if (bit_end) begin
                        sbit <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: load on completion if free or freed this cycle, else drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            if (frame_done) begin
                break_det <= done_brk;
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= done_pe;
                    frame_err  <= done_fe;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 8E1, 7O2) at
// DIV=10, 16x oversampling (160 clocks per bit). Expected frames are queued
// by the stimulus and popped by a monitor on each valid/ready handshake.
module tb_uart_rx_cfg;

    localparam int BIT = 160;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx_en;
    logic [2:0] rxl;
    logic [2:0] rdy;
    wire  [2:0] vld, pe, fe, brk, ovr, bsy;
    wire  [7:0] dat0, dat1;
    wire  [6:0] dat2;

    int n_checks = 0;
    int n_errs   = 0;
    int ovr_cnt0 = 0;
    int brk_cnt0 = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    uart_rx_cfg #(.CLK_FREQ(1_536_000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) dut_8n1 (
        .clk(clk), .reset(reset), .rx(rxl[0]), .rx_en(rx_en), .rx_data(dat0),
        .rx_valid(vld[0]), .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .break_det(brk[0]), .overrun_err(ovr[0]), .busy(bsy[0]));

    uart_rx_cfg #(.CLK_FREQ(1_536_000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(16)) dut_8e1 (
        .clk(clk), .reset(reset), .rx(rxl[1]), .rx_en(rx_en), .rx_data(dat1),
        .rx_valid(vld[1]), .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .break_det(brk[1]), .overrun_err(ovr[1]), .busy(bsy[1]));

    uart_rx_cfg #(.CLK_FREQ(1_536_000), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .OVERSAMPLE(16)) dut_7o2 (
        .clk(clk), .reset(reset), .rx(rxl[2]), .rx_en(rx_en), .rx_data(dat2),
        .rx_valid(vld[2]), .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .break_det(brk[2]), .overrun_err(ovr[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic push(input int id, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d; e.pe = p; e.fe = f;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_check(input int id, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        logic have;
        have = 1'b0;
        case (id)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_errs++;
            $display("FAIL unexpected_frame[%0d]: got data 0x%0h, required no frame", id, d);
        end else begin
            check($sformatf("data[%0d]", id), 32'(d), 32'(e.d));
            check($sformatf("parity_err[%0d]", id), 32'(p), 32'(e.pe));
            check($sformatf("frame_err[%0d]", id), 32'(f), 32'(e.fe));
        end
    endtask

    // Monitor: pops on every handshake and counts error pulses of receiver 0.
    always @(negedge clk) begin
        if (vld[0] && rdy[0]) pop_check(0, {1'b0, dat0}, pe[0], fe[0]);
        if (vld[1] && rdy[1]) pop_check(1, {1'b0, dat1}, pe[1], fe[1]);
        if (vld[2] && rdy[2]) pop_check(2, {2'b00, dat2}, pe[2], fe[2]);
        if (ovr[0]) ovr_cnt0++;
        if (brk[0]) brk_cnt0++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input int n);
        rxl[id] = v;
        cyc(n);
    endtask

    // par < 0: no parity bit; spike >= 0: one-tick inverted pulse mid data bit.
    task automatic send_frame(input int id, input logic [8:0] data, input int nbits,
                              input int par, input int nstop, input int spike);
        drive(id, 1'b0, BIT);
        for (int i = 0; i < nbits; i++) begin
            if (i == spike) begin
                drive(id, data[i], 80);
                drive(id, ~data[i], 10);
                drive(id, data[i], 70);
            end else begin
                drive(id, data[i], BIT);
            end
        end
        if (par >= 0) drive(id, par[0], BIT);
        drive(id, 1'b1, nstop * BIT);
    endtask

    task automatic accept0();
        rdy[0] = 1'b1;
        cyc(1);
        rdy[0] = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, required end of test");
        n_errs++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        logic seen;
        int   k;
        int   ovr_before;
        int   brk_before;

        reset = 1'b0;
        rx_en = 1'b1;
        rxl   = 3'b111;
        rdy   = 3'b000;
        cyc(5);
        check("reset_valid", 32'(vld), 32'h0);
        check("reset_busy", 32'(bsy), 32'h0);
        check("reset_flags", 32'({pe, fe, brk, ovr}), 32'h0);
        check("reset_data0", 32'(dat0), 32'h0);
        reset = 1'b1;
        cyc(2 * BIT);

        // 1: 8N1 0xA5 held without ready, then accepted.
        push(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, -1, 1, -1);
        check("t1_valid", 32'(vld[0]), 32'h1);
        check("t1_data", 32'(dat0), 32'hA5);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (vld[0] !== 1'b1 || dat0 !== 8'hA5) stable = 1'b0;
        end
        check("t1_hold", 32'(stable), 32'h1);
        accept0();
        check("t1_valid_cleared", 32'(vld[0]), 32'h0);

        // 2: 8E1 with wrong parity bit; 7O2 with correct parity.
        rdy[1] = 1'b1;
        rdy[2] = 1'b1;
        push(1, 9'h03C, 1'b1, 1'b0);
        push(2, 9'h055, 1'b0, 1'b0);
        fork
            send_frame(1, 9'h03C, 8, 1, 1, -1);
            send_frame(2, 9'h055, 7, 1, 2, -1);
        join
        cyc(BIT);

        // 3: short low glitch is rejected; a one-tick spike is outvoted.
        rdy[0] = 1'b1;
        seen = 1'b0;
        rxl[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin cyc(1); if (bsy[0]) seen = 1'b1; end
        rxl[0] = 1'b1;
        for (int i = 0; i < BIT - 30; i++) begin cyc(1); if (bsy[0]) seen = 1'b1; end
        check("t3_glitch_seen", 32'(seen), 32'h1);
        check("t3_glitch_idle", 32'(bsy[0]), 32'h0);
        check("t3_glitch_novalid", 32'(vld[0]), 32'h0);
        cyc(BIT);
        push(0, 9'h081, 1'b0, 1'b0);
        send_frame(0, 9'h081, 8, -1, 1, 3);
        cyc(BIT);

        // 4a: back-to-back without ready -> second frame dropped.
        rdy[0] = 1'b0;
        ovr_before = ovr_cnt0;
        push(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 8, -1, 1, -1);
        send_frame(0, 9'h022, 8, -1, 1, -1);
        check("t4_overrun_once", 32'(ovr_cnt0 - ovr_before), 32'h1);
        check("t4_data_kept", 32'(dat0), 32'h11);
        check("t4_valid_kept", 32'(vld[0]), 32'h1);
        accept0();
        cyc(BIT);

        // 4b: ready pulsed exactly in the completion cycle of the second frame
        // (decision tick of the stop bit = 153 ticks = 1530 clocks after start).
        push(0, 9'h033, 1'b0, 1'b0);
        send_frame(0, 9'h033, 8, -1, 1, -1);
        push(0, 9'h044, 1'b0, 1'b0);
        ovr_before = ovr_cnt0;
        fork
            send_frame(0, 9'h044, 8, -1, 1, -1);
            begin
                k = 0;
                while (!bsy[0] && k < 400) begin cyc(1); k++; end
                check("t4_busy_rise", 32'(bsy[0]), 32'h1);
                cyc(1529);
                rdy[0] = 1'b1;
                cyc(1);
                rdy[0] = 1'b0;
            end
        join
        check("t4_no_overrun", 32'(ovr_cnt0 - ovr_before), 32'h0);
        check("t4_new_data", 32'(dat0), 32'h44);
        check("t4_new_valid", 32'(vld[0]), 32'h1);
        accept0();
        cyc(BIT);

        // 5: break, then a clean frame once the line has returned high.
        rdy[0] = 1'b1;
        brk_before = brk_cnt0;
        push(0, 9'h000, 1'b0, 1'b1);
        drive(0, 1'b0, 12 * BIT);
        check("t5_break_pulse", 32'(brk_cnt0 - brk_before), 32'h1);
        check("t5_idle_in_break", 32'(bsy[0]), 32'h0);
        drive(0, 1'b1, 2 * BIT);
        push(0, 9'h07E, 1'b0, 1'b0);
        send_frame(0, 9'h07E, 8, -1, 1, -1);
        cyc(BIT);
        check("t5_data_after", 32'(dat0), 32'h7E);

        // 6: reset in the middle of the data bits of 0xF0.
        fork
            send_frame(0, 9'h0F0, 8, -1, 1, -1);
            begin
                cyc(560);
                check("t6_busy_mid", 32'(bsy[0]), 32'h1);
                reset = 1'b0;
                cyc(1);
                check("t6_outputs_zero",
                      32'({vld[0], bsy[0], pe[0], fe[0], brk[0], ovr[0], dat0}), 32'h0);
                reset = 1'b1;
            end
        join
        cyc(BIT);
        check("t6_no_aborted_frame", 32'(vld[0]), 32'h0);
        push(0, 9'h05A, 1'b0, 1'b0);
        send_frame(0, 9'h05A, 8, -1, 1, -1);
        cyc(2 * BIT);

        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q2_drained", 32'(q2.size()), 32'h0);
        check("total_overruns", 32'(ovr_cnt0), 32'h1);
        check("total_breaks", 32'(brk_cnt0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
